// File: rtl/stream_demux_pkg.sv
// Shared helpers for the registered N-way stream demultiplexer.
package stream_demux_pkg;

  // Select width for an N-way demux; never below one bit so N=1 corner stays legal.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Saturation value of a cw-bit up-counter.
  function automatic logic [31:0] cnt_max(input int unsigned cw);
    return (cw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cw) - 32'd1);
  endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// Single-entry output register for one demux channel with same-cycle drain and refill.
module demux_chan_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         free
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Empty, or the held word leaves this cycle.
  assign free = !valid_q | ready;

  always_comb begin
    valid_d = valid_q & !ready;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/stream_demux_n.sv
// Registered 1-to-N stream demultiplexer with broadcast and out-of-range drop accounting.
module stream_demux_n
  import stream_demux_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 8,
  parameter int unsigned CW = 8,
  localparam int unsigned SW = sel_width(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic [SW-1:0]  in_sel,
  input  logic           in_bcast,
  output logic [N-1:0]   out_valid,
  input  logic [N-1:0]   out_ready,
  output logic [N*W-1:0] out_data,
  output logic           drop_err,
  output logic [CW-1:0]  drop_cnt
);

  localparam logic [CW-1:0] CntMax = CW'(cnt_max(CW));

  logic [N-1:0]  free;
  logic [N-1:0]  load;
  logic          sel_in_range;
  logic          xfer;
  logic          drop;
  logic          drop_err_q;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  assign sel_in_range = (32'(in_sel) < N);

  // Out-of-range words are always accepted so the producer never stalls on them.
  always_comb begin
    in_ready = 1'b1;
    if (in_bcast) begin
      in_ready = &free;
    end else if (sel_in_range) begin
      in_ready = free[in_sel];
    end
  end

  assign xfer = in_valid & in_ready;
  assign drop = xfer & !in_bcast & !sel_in_range;

  for (genvar i = 0; i < N; i++) begin : g_chan
    assign load[i] = xfer & (in_bcast | (sel_in_range & (in_sel == SW'(i))));

    demux_chan_reg #(
      .W (W)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[i]),
      .load_data (in_data),
      .ready     (out_ready[i]),
      .valid     (out_valid[i]),
      .data      (out_data[i*W +: W]),
      .free      (free[i])
    );
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != CntMax)) begin
      drop_cnt_d = drop_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_err_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      drop_err_q <= drop;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_err = drop_err_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux_n.sv
// Directed bench for stream_demux_n: a 4-way instance plus two 3-way instances (CW=8, CW=2).
module tb_stream_demux_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // 4-way instance
  logic        v4, b4, rdy4, de4;
  logic [7:0]  d4, dc4;
  logic [1:0]  s4;
  logic [3:0]  or4, ov4;
  logic [31:0] od4;

  // 3-way instances share stimulus
  logic        v3, b3, rdy3, de3, rdy3s, de3s;
  logic [7:0]  d3, dc3;
  logic [1:0]  s3, dc3s;
  logic [2:0]  or3, ov3, ov3s;
  logic [23:0] od3, od3s;

  stream_demux_n #(.N(4), .W(8), .CW(8)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4), .in_data(d4), .in_sel(s4),
    .in_bcast(b4), .out_valid(ov4), .out_ready(or4), .out_data(od4), .drop_err(de4),
    .drop_cnt(dc4)
  );

  stream_demux_n #(.N(3), .W(8), .CW(8)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(rdy3), .in_data(d3), .in_sel(s3),
    .in_bcast(b3), .out_valid(ov3), .out_ready(or3), .out_data(od3), .drop_err(de3),
    .drop_cnt(dc3)
  );

  stream_demux_n #(.N(3), .W(8), .CW(2)) u3s (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(rdy3s), .in_data(d3), .in_sel(s3),
    .in_bcast(b3), .out_valid(ov3s), .out_ready(or3), .out_data(od3s), .drop_err(de3s),
    .drop_cnt(dc3s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    v4 = 0; b4 = 0; d4 = 0; s4 = 0; or4 = 0;
    v3 = 0; b3 = 0; d3 = 0; s3 = 0; or3 = 0;
    rst_n = 0;
    #12;
    rst_n = 1;
    tick();
    checks++;
    if (ov4 !== 4'b0000) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0000", ov4);
    end
    checks++;
    if (od4 !== 32'h0) begin
      errors++; $display("FAIL reset_out_data: got %h expected 00000000", od4);
    end
    checks++;
    if (de4 !== 1'b0 || dc4 !== 8'd0) begin
      errors++; $display("FAIL reset_drop: got err=%b cnt=%0d expected err=0 cnt=0", de4, dc4);
    end
    checks++;
    if (rdy4 !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", rdy4);
    end
    checks++;
    if (ov3 !== 3'b000 || dc3 !== 8'd0 || dc3s !== 2'd0) begin
      errors++; $display("FAIL reset_n3: got ov=%b cnt=%0d cnts=%0d expected 000/0/0",
                         ov3, dc3, dc3s);
    end
  endtask

  task automatic test_unicast();
    or4 = 4'b0000;
    v4 = 1; s4 = 2'd2; d4 = 8'hA5; b4 = 0;
    #1;
    checks++;
    if (rdy4 !== 1'b1) begin
      errors++; $display("FAIL unicast_ready: got %b expected 1", rdy4);
    end
    tick();
    d4 = 8'h5A;
    #1;
    checks++;
    if (ov4 !== 4'b0100) begin
      errors++; $display("FAIL unicast_valid: got %b expected 0100", ov4);
    end
    checks++;
    if (od4[23:16] !== 8'hA5) begin
      errors++; $display("FAIL unicast_data: got %h expected a5", od4[23:16]);
    end
    checks++;
    if (rdy4 !== 1'b0) begin
      errors++; $display("FAIL unicast_full_ready: got %b expected 0", rdy4);
    end
    tick();
    v4 = 0;
    checks++;
    if (od4[23:16] !== 8'hA5 || ov4 !== 4'b0100) begin
      errors++; $display("FAIL unicast_hold: got %h/%b expected a5/0100", od4[23:16], ov4);
    end
    or4 = 4'b0100;
    tick();
    or4 = 4'b0000;
    checks++;
    if (ov4 !== 4'b0000 || od4[23:16] !== 8'hA5) begin
      errors++; $display("FAIL unicast_drain: got %b/%h expected 0000/a5", ov4, od4[23:16]);
    end
  endtask

  task automatic test_back_to_back();
    or4 = 4'b0010;
    v4 = 1; s4 = 2'd1; b4 = 0;
    for (int i = 0; i < 3; i++) begin
      d4 = 8'(i + 1);
      #1;
      checks++;
      if (rdy4 !== 1'b1) begin
        errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, rdy4);
      end
      tick();
      checks++;
      if (ov4 !== 4'b0010 || od4[15:8] !== 8'(i + 1)) begin
        errors++; $display("FAIL b2b_word[%0d]: got %b/%h expected 0010/%h",
                           i, ov4, od4[15:8], 8'(i + 1));
      end
    end
    v4 = 0;
    tick();
    checks++;
    if (ov4 !== 4'b0000) begin
      errors++; $display("FAIL b2b_drain: got %b expected 0000", ov4);
    end
    or4 = 4'b0000;
  endtask

  task automatic test_broadcast_blocked();
    v4 = 1; s4 = 2'd3; d4 = 8'h77; b4 = 0; or4 = 4'b0000;
    tick();
    v4 = 1; b4 = 1; d4 = 8'h3C; s4 = 2'd0;
    #1;
    checks++;
    if (rdy4 !== 1'b0) begin
      errors++; $display("FAIL bcast_blocked: got %b expected 0", rdy4);
    end
    tick();
    checks++;
    if (rdy4 !== 1'b0 || ov4 !== 4'b1000 || od4[31:24] !== 8'h77) begin
      errors++; $display("FAIL bcast_still_blocked: got rdy=%b ov=%b d3=%h expected 0/1000/77",
                         rdy4, ov4, od4[31:24]);
    end
    or4 = 4'b1000;
    #1;
    checks++;
    if (rdy4 !== 1'b1) begin
      errors++; $display("FAIL bcast_unblocked: got %b expected 1", rdy4);
    end
    tick();
    v4 = 0; b4 = 0; or4 = 4'b0000;
    checks++;
    if (ov4 !== 4'b1111 || od4 !== 32'h3C3C3C3C) begin
      errors++; $display("FAIL bcast_result: got %b/%h expected 1111/3c3c3c3c", ov4, od4);
    end
    or4 = 4'b1111;
    tick();
    or4 = 4'b0000;
  endtask

  task automatic test_independence();
    v4 = 1; s4 = 2'd0; d4 = 8'h11; b4 = 0; or4 = 4'b0000;
    tick();
    or4 = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      s4 = (i % 2 == 0) ? 2'd1 : 2'd2;
      d4 = 8'h21 + 8'(i);
      #1;
      checks++;
      if (rdy4 !== 1'b1) begin
        errors++; $display("FAIL indep_ready[%0d]: got %b expected 1", i, rdy4);
      end
      tick();
      checks++;
      if (od4[7:0] !== 8'h11 || ov4[0] !== 1'b1 || od4[s4*8 +: 8] !== 8'h21 + 8'(i)) begin
        errors++; $display("FAIL indep_word[%0d]: got ch0=%h v0=%b ch%0d=%h expected 11/1/%h",
                           i, od4[7:0], ov4[0], s4, od4[s4*8 +: 8], 8'h21 + 8'(i));
      end
    end
    v4 = 0;
    or4 = 4'b1111;
    tick();
    or4 = 4'b0000;
  endtask

  task automatic test_out_of_range();
    or3 = 3'b000; b3 = 0; s3 = 2'd3; d3 = 8'hFF;
    for (int k = 1; k <= 2; k++) begin
      v3 = 1;
      #1;
      checks++;
      if (rdy3 !== 1'b1 || rdy3s !== 1'b1) begin
        errors++; $display("FAIL oor_ready[%0d]: got %b/%b expected 1/1", k, rdy3, rdy3s);
      end
      tick();
      v3 = 0;
      checks++;
      if (de3 !== 1'b1 || dc3 !== 8'(k) || de3s !== 1'b1) begin
        errors++; $display("FAIL oor_pulse[%0d]: got err=%b cnt=%0d errs=%b expected 1/%0d/1",
                           k, de3, dc3, de3s, k);
      end
      tick();
      checks++;
      if (de3 !== 1'b0 || dc3 !== 8'(k)) begin
        errors++; $display("FAIL oor_pulse_end[%0d]: got err=%b cnt=%0d expected 0/%0d",
                           k, de3, dc3, k);
      end
    end
    checks++;
    if (ov3 !== 3'b000 || ov3s !== 3'b000 || od3 !== 24'h0 || od3s !== 24'h0) begin
      errors++; $display("FAIL oor_no_change: got %b/%b %h/%h expected 000/000 0/0",
                         ov3, ov3s, od3, od3s);
    end
    for (int k = 0; k < 3; k++) begin
      v3 = 1;
      tick();
      v3 = 0;
      tick();
    end
    checks++;
    if (dc3 !== 8'd5) begin
      errors++; $display("FAIL oor_count5: got %0d expected 5", dc3);
    end
    checks++;
    if (dc3s !== 2'd3) begin
      errors++; $display("FAIL oor_saturate: got %0d expected 3", dc3s);
    end
  endtask

  task automatic test_reset_mid();
    b4 = 0; or4 = 4'b0000; v4 = 1;
    s4 = 2'd0; d4 = 8'hA0; tick();
    s4 = 2'd1; d4 = 8'hA1; tick();
    s4 = 2'd3; d4 = 8'hA3; tick();
    v4 = 0;
    v3 = 1; b3 = 0; or3 = 3'b000;
    s3 = 2'd0; d3 = 8'hB0; tick();
    s3 = 2'd1; d3 = 8'hB1; tick();
    v3 = 0;
    checks++;
    if (ov4 !== 4'b1011 || ov3 !== 3'b011 || dc3 !== 8'd5) begin
      errors++; $display("FAIL rstmid_pre: got %b/%b/%0d expected 1011/011/5", ov4, ov3, dc3);
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (ov4 !== 4'b0000 || od4 !== 32'h0 || ov3 !== 3'b000) begin
      errors++; $display("FAIL rstmid_valid: got %b/%h/%b expected 0000/0/000", ov4, od4, ov3);
    end
    checks++;
    if (dc3 !== 8'd0 || dc3s !== 2'd0) begin
      errors++; $display("FAIL rstmid_cnt: got %0d/%0d expected 0/0", dc3, dc3s);
    end
    #3;
    rst_n = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_back_to_back();
    test_broadcast_blocked();
    test_independence();
    test_out_of_range();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
